lru_update_arbiter: RTL and testbench

- Shares the single update port of the set-associative LRU bank between two requesters:
  - the CPU side (access touches and invalidates);
  - the snoopy side (invalidates caused by bus snoops).
- Snoop invalidates are buffered in a small FIFO so the snoop controller never stalls the CPU pipeline.
- A starvation counter guarantees forward progress for queued snoop updates.
- Sits between the cache controllers and the set-associative LRU. It drives that block's index, lastAccessedCacheLine, accessEnable and invalidateEnable inputs.

---
 rtl/lru_arbiter_pkg.sv | 21 ++
 rtl/snoop_invalidate_fifo.sv | 67 ++++++
 rtl/lru_update_arbiter.sv | 146 ++++++++++++++
 tb/tb_lru_update_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/lru_arbiter_pkg.sv
// lru_arbiter_pkg
//   Shared types and helpers for the LRU update arbiter and its snoop queue.
//   - update_kind_t : which kind of update (if any) is sent to the LRU bank.
//   - lineWidthOf() : way-select width for a given number of ways.
//   The snoop queue entry {index, line} is declared as a packed struct in the
//   arbiter, where the index and way widths are known, and is handed to the
//   queue as a type parameter.
package lru_arbiter_pkg;

   typedef enum logic [1:0] {
      UPDATE_NONE,
      UPDATE_ACCESS,
      UPDATE_INVALIDATE
   } update_kind_t;

   // A single-way cache still needs a one-bit line field to stay legal.
   function automatic int lineWidthOf(input int lines);
      return (lines > 1) ? $clog2(lines) : 1;
   endfunction

endpackage

// File: rtl/snoop_invalidate_fifo.sv
// snoop_invalidate_fifo
//   Synchronous FIFO holding pending snoop invalidates.
//   Ports:
//     clock     rising-edge clock
//     reset     synchronous, active-low; empties the queue
//     push      write pushData (ignored while full, even if popping)
//     pushData  entry to enqueue
//     pop       remove the head entry (ignored while empty)
//     headData  oldest entry, valid while !empty
//     full      count == FIFO_DEPTH
//     empty     count == 0
//     count     current occupancy
module snoop_invalidate_fifo #(
   parameter type entry_t    = logic [7:0],
   parameter int  FIFO_DEPTH = 4,
   localparam int PTR_W      = $clog2(FIFO_DEPTH),
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  entry_t           pushData,
   input  logic             pop,
   output entry_t           headData,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   entry_t           storage [FIFO_DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic             pushEn;
   logic             popEn;

   assign full     = (count == CNT_W'(FIFO_DEPTH));
   assign empty    = (count == '0);
   assign headData = storage[rdPtr];

   // The full test uses the current count only, so a pop never frees a slot
   // for a push in the same cycle.
   assign pushEn = push && !full;
   assign popEn  = pop && !empty;

   // Pointers are plain binary counters; the power-of-two depth makes the
   // natural overflow the wrap.
   always_ff @(posedge clock) begin
      if (!reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (pushEn) wrPtr <= wrPtr + PTR_W'(1);
         if (popEn)  rdPtr <= rdPtr + PTR_W'(1);
         case ({pushEn, popEn})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (pushEn) storage[wrPtr] <= pushData;
   end

endmodule

// File: rtl/lru_update_arbiter.sv
// lru_update_arbiter
//   Shares the single update port of the set-associative LRU bank between the
//   CPU side (touches and invalidates) and queued snoop invalidates. A
//   starvation counter bounds how long a queued snoop can wait behind the CPU.
//   Ports:
//     clock, reset            rising-edge clock, synchronous active-low reset
//     cpuAccessRequest        CPU touch request
//     cpuInvalidateRequest    CPU invalidate request (wins over touch)
//     cpuIndex, cpuLine       set / way of the CPU request
//     cpuGrant                combinational: CPU request accepted this cycle
//     snoopyInvalidateRequest snoop invalidate push request
//     snoopyIndex, snoopyLine set / way of the snoop invalidate
//     snoopyReady             combinational: queue can accept a push
//     lruIndex, lruLine       registered set / way to the LRU bank
//     lruAccessEnable         registered one-cycle touch pulse
//     lruInvalidateEnable     registered one-cycle invalidate pulse
//     queueCount              snoop queue occupancy
module lru_update_arbiter
   import lru_arbiter_pkg::*;
#(
   parameter int  INDEX_WIDTH           = 6,
   parameter int  NUMBER_OF_CACHE_LINES = 4,
   parameter int  FIFO_DEPTH            = 4,
   parameter int  STARVATION_LIMIT      = 4,
   localparam int LINE_WIDTH            = lineWidthOf(NUMBER_OF_CACHE_LINES),
   localparam int COUNT_WIDTH           = $clog2(FIFO_DEPTH) + 1,
   localparam int STARVE_WIDTH          = $clog2(STARVATION_LIMIT + 1)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   cpuAccessRequest,
   input  logic                   cpuInvalidateRequest,
   input  logic [INDEX_WIDTH-1:0] cpuIndex,
   input  logic [LINE_WIDTH-1:0]  cpuLine,
   output logic                   cpuGrant,
   input  logic                   snoopyInvalidateRequest,
   input  logic [INDEX_WIDTH-1:0] snoopyIndex,
   input  logic [LINE_WIDTH-1:0]  snoopyLine,
   output logic                   snoopyReady,
   output logic [INDEX_WIDTH-1:0] lruIndex,
   output logic [LINE_WIDTH-1:0]  lruLine,
   output logic                   lruAccessEnable,
   output logic                   lruInvalidateEnable,
   output logic [COUNT_WIDTH-1:0] queueCount
);

   typedef struct packed {
      logic [INDEX_WIDTH-1:0] index;
      logic [LINE_WIDTH-1:0]  line;
   } snoop_entry_t;

   snoop_entry_t            pushEntry;
   snoop_entry_t            headEntry;
   logic                    queueFull;
   logic                    queueEmpty;
   logic                    pushReq;
   logic                    popSel;
   logic                    cpuRequest;
   logic [STARVE_WIDTH-1:0] starveCount;

   update_kind_t            issueKind_p0;
   logic [INDEX_WIDTH-1:0]  issueIndex_p0;
   logic [LINE_WIDTH-1:0]   issueLine_p0;

   logic [INDEX_WIDTH-1:0]  lruIndex_p1;
   logic [LINE_WIDTH-1:0]   lruLine_p1;
   logic                    accessVld_p1;
   logic                    invalidateVld_p1;

   assign pushEntry   = '{index: snoopyIndex, line: snoopyLine};
   assign snoopyReady = reset && !queueFull;
   assign pushReq     = snoopyInvalidateRequest && snoopyReady;
   assign cpuRequest  = cpuAccessRequest || cpuInvalidateRequest;

   // The snoop queue wins when it is full, when the CPU has used up its
   // allowance of consecutive grants, or when the CPU is idle.
   assign popSel   = reset && !queueEmpty &&
                     (queueFull || starveCount == STARVE_WIDTH'(STARVATION_LIMIT) || !cpuRequest);
   assign cpuGrant = reset && cpuRequest && !popSel;

   snoop_invalidate_fifo #(
      .entry_t    (snoop_entry_t),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) snoopQueue (
      .clock    (clock),
      .reset    (reset),
      .push     (pushReq),
      .pushData (pushEntry),
      .pop      (popSel),
      .headData (headEntry),
      .full     (queueFull),
      .empty    (queueEmpty),
      .count    (queueCount)
   );

   // Counts CPU grants taken while a snoop is waiting; any pop, or an empty
   // queue, means nothing is being starved.
   always_ff @(posedge clock) begin
      if (!reset) begin
         starveCount <= '0;
      end else if (popSel || queueEmpty) begin
         starveCount <= '0;
      end else if (cpuGrant && starveCount != STARVE_WIDTH'(STARVATION_LIMIT)) begin
         starveCount <= starveCount + STARVE_WIDTH'(1);
      end
   end

   // Stage p0: select the update for this cycle
   always_comb begin
      issueKind_p0  = UPDATE_NONE;
      issueIndex_p0 = '0;
      issueLine_p0  = '0;
      if (popSel) begin
         issueKind_p0  = UPDATE_INVALIDATE;
         issueIndex_p0 = headEntry.index;
         issueLine_p0  = headEntry.line;
      end else if (cpuGrant) begin
         issueKind_p0  = cpuInvalidateRequest ? UPDATE_INVALIDATE : UPDATE_ACCESS;
         issueIndex_p0 = cpuIndex;
         issueLine_p0  = cpuLine;
      end
   end

   // Stage p1: registered drive of the LRU bank update port
   always_ff @(posedge clock) begin
      if (!reset) begin
         lruIndex_p1      <= '0;
         lruLine_p1       <= '0;
         accessVld_p1     <= 1'b0;
         invalidateVld_p1 <= 1'b0;
      end else begin
         accessVld_p1     <= (issueKind_p0 == UPDATE_ACCESS);
         invalidateVld_p1 <= (issueKind_p0 == UPDATE_INVALIDATE);
         if (issueKind_p0 != UPDATE_NONE) begin
            lruIndex_p1 <= issueIndex_p0;
            lruLine_p1  <= issueLine_p0;
         end
      end
   end

   assign lruIndex            = lruIndex_p1;
   assign lruLine             = lruLine_p1;
   assign lruAccessEnable     = accessVld_p1;
   assign lruInvalidateEnable = invalidateVld_p1;

endmodule

// File: tb/tb_lru_update_arbiter.sv
// tb_lru_update_arbiter
//   Directed scenarios followed by randomized traffic, all checked against a
//   queue-based reference model of the arbitration rules.
module tb_lru_update_arbiter;

   localparam int IW    = 6;
   localparam int LW    = 2;
   localparam int DEPTH = 4;
   localparam int LIMIT = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic          cpuAccessRequest;
   logic          cpuInvalidateRequest;
   logic [IW-1:0] cpuIndex;
   logic [LW-1:0] cpuLine;
   logic          cpuGrant;
   logic          snoopyInvalidateRequest;
   logic [IW-1:0] snoopyIndex;
   logic [LW-1:0] snoopyLine;
   logic          snoopyReady;
   logic [IW-1:0] lruIndex;
   logic [LW-1:0] lruLine;
   logic          lruAccessEnable;
   logic          lruInvalidateEnable;
   logic [2:0]    queueCount;

   always #5 clock = ~clock;

   lru_update_arbiter #(
      .INDEX_WIDTH           (IW),
      .NUMBER_OF_CACHE_LINES (4),
      .FIFO_DEPTH            (DEPTH),
      .STARVATION_LIMIT      (LIMIT)
   ) dut (
      .clock                   (clock),
      .reset                   (reset),
      .cpuAccessRequest        (cpuAccessRequest),
      .cpuInvalidateRequest    (cpuInvalidateRequest),
      .cpuIndex                (cpuIndex),
      .cpuLine                 (cpuLine),
      .cpuGrant                (cpuGrant),
      .snoopyInvalidateRequest (snoopyInvalidateRequest),
      .snoopyIndex             (snoopyIndex),
      .snoopyLine              (snoopyLine),
      .snoopyReady             (snoopyReady),
      .lruIndex                (lruIndex),
      .lruLine                 (lruLine),
      .lruAccessEnable         (lruAccessEnable),
      .lruInvalidateEnable     (lruInvalidateEnable),
      .queueCount              (queueCount)
   );

   // Reference model state
   typedef struct {
      int idx;
      int line;
   } entry_t;

   entry_t modelQ[$];
   int     modelStarve = 0;
   int     expIndex    = 0;
   int     expLine     = 0;
   int     expAccess   = 0;
   int     expInval    = 0;
   bit     lastGrant;
   bit     lastPushOk;

   int checks = 0;
   int passes = 0;

   task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp)
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      else
         passes++;
   endtask

   // One clock cycle: drive, check combinational outputs, advance the model,
   // then check the registered outputs after the edge.
   task automatic step(input bit rstN, input bit ca, input bit ci, input int cIdx, input int cLn,
                       input bit sr, input int sIdx, input int sLn);
      bit     eGrant, eReady, ePop, wasEmpty;
      entry_t head;
      @(negedge clock);
      reset                   = rstN;
      cpuAccessRequest        = ca;
      cpuInvalidateRequest    = ci;
      cpuIndex                = IW'(cIdx);
      cpuLine                 = LW'(cLn);
      snoopyInvalidateRequest = sr;
      snoopyIndex             = IW'(sIdx);
      snoopyLine              = LW'(sLn);
      #1;
      if (!rstN) begin
         eGrant = 0; eReady = 0; ePop = 0;
      end else begin
         eReady = (modelQ.size() < DEPTH);
         ePop   = (modelQ.size() > 0) &&
                  (modelQ.size() == DEPTH || modelStarve == LIMIT || !(ca || ci));
         eGrant = (ca || ci) && !ePop;
      end
      checkEq("cpuGrant", cpuGrant, eGrant);
      checkEq("snoopyReady", snoopyReady, eReady);
      checkEq("queueCount", queueCount, modelQ.size());
      lastGrant  = eGrant;
      lastPushOk = sr && eReady;

      if (!rstN) begin
         modelQ.delete();
         modelStarve = 0;
         expIndex = 0; expLine = 0; expAccess = 0; expInval = 0;
      end else begin
         wasEmpty  = (modelQ.size() == 0);
         expAccess = 0;
         expInval  = 0;
         if (ePop) begin
            head     = modelQ.pop_front();
            expInval = 1;
            expIndex = head.idx;
            expLine  = head.line;
         end else if (eGrant) begin
            if (ci) expInval = 1; else expAccess = 1;
            expIndex = cIdx;
            expLine  = cLn;
         end
         if (ePop || wasEmpty) modelStarve = 0;
         else if (eGrant && modelStarve < LIMIT) modelStarve++;
         if (sr && eReady) modelQ.push_back('{idx: sIdx, line: sLn});
      end

      @(posedge clock);
      #1;
      checkEq("lruAccessEnable", lruAccessEnable, expAccess);
      checkEq("lruInvalidateEnable", lruInvalidateEnable, expInval);
      checkEq("lruIndex", lruIndex, expIndex);
      checkEq("lruLine", lruLine, expLine);
   endtask

   bit cpuPend, snPend, ca, ci, sr, rstN;
   int cIdx, cLn, sIdx, sLn, mode;

   initial begin
      reset = 1'b0;
      cpuAccessRequest = 0; cpuInvalidateRequest = 0; cpuIndex = '0; cpuLine = '0;
      snoopyInvalidateRequest = 0; snoopyIndex = '0; snoopyLine = '0;
      repeat (2) @(posedge clock);

      // Reset held with every request high
      repeat (3) step(0, 1, 1, 3, 1, 1, 7, 2);

      // CPU-only access, then idle
      step(1, 1, 0, 5, 2, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);

      // Snoop-only push, drained with the CPU idle
      step(1, 0, 0, 0, 0, 1, 9, 1);
      repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0);

      // Starvation: one queued snoop behind continuous CPU access
      step(1, 1, 0, 1, 0, 1, 12, 3);
      for (int i = 0; i < 7; i++) step(1, 1, 0, 20 + i, i % 4, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);

      // Fill the queue while the CPU is busy; extra pushes are held
      for (int i = 0; i < 8; i++) step(1, 1, 0, 30 + i, 1, 1, 40 + i, i % 4);
      repeat (6) step(1, 0, 0, 0, 0, 0, 0, 0);

      // Push and pop together at count 2 with the CPU idle
      step(1, 1, 0, 2, 2, 1, 50, 0);
      step(1, 1, 0, 2, 2, 1, 51, 1);
      step(1, 0, 0, 0, 0, 1, 52, 2);
      repeat (4) step(1, 0, 0, 0, 0, 0, 0, 0);

      // Both CPU requests: invalidate wins
      step(1, 1, 1, 3, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);

      // Reset with two queued entries
      step(1, 1, 0, 4, 1, 1, 60, 1);
      step(1, 1, 0, 4, 1, 1, 61, 2);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0);

      // Randomized traffic obeying the hold-until-accepted handshakes
      cpuPend = 0; snPend = 0;
      ca = 0; ci = 0; sr = 0; cIdx = 0; cLn = 0; sIdx = 0; sLn = 0;
      for (int n = 0; n < 3000; n++) begin
         rstN = ($urandom_range(0, 199) != 0);
         if (!cpuPend && $urandom_range(0, 2) != 0) begin
            cpuPend = 1;
            mode = $urandom_range(0, 3);
            ca   = (mode != 1);
            ci   = (mode == 1 || mode == 3);
            cIdx = $urandom_range(0, 63);
            cLn  = $urandom_range(0, 3);
         end
         if (!snPend && $urandom_range(0, 1) != 0) begin
            snPend = 1;
            sIdx = $urandom_range(0, 63);
            sLn  = $urandom_range(0, 3);
         end
         step(rstN, cpuPend && ca, cpuPend && ci, cIdx, cLn, snPend, sIdx, sLn);
         if (!rstN) begin
            cpuPend = 0;
            snPend  = 0;
         end else begin
            if (lastGrant)  cpuPend = 0;
            if (lastPushOk) snPend  = 0;
         end
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
